id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width in bits.
REQ-002 SHALL have ports exactly as follows; one clock, reset asynchronous active-low:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  downstream hold; stage register keeps contents
flush  input  1  squash (taken branch); stage loads a bubble
id_valid  input  1  decode slot holds a real instruction
id_pc  input  XLEN  decode-stage PC
id_rs1_data  input  XLEN  register-file read data, source 1
id_rs2_data  input  XLEN  register-file read data, source 2
id_imm  input  XLEN  sign-extended immediate
id_rs1  input  5  source-1 register index
id_rs2  input  5  source-2 register index
id_rd  input  5  destination register index
id_alu_op  input  3  ALU operation code
id_alu_src  input  1  1 = operand B is immediate
id_ctrl  input  4  {reg_write, mem_read, mem_write, branch}
exm_rd  input  5  EX/MEM destination index
exm_we  input  1  EX/MEM writes register file
exm_res  input  XLEN  EX/MEM ALU result
wb_rd  input  5  MEM/WB destination index
wb_we  input  1  MEM/WB writes register file
wb_res  input  XLEN  MEM/WB writeback value
ex_valid  output  1  execute slot holds a real instruction
ex_pc  output  XLEN  registered PC
Alu_op  output  3  ALU operation code to ALU
alu_a  output  XLEN  forwarded operand A to ALU rs1
alu_b  output  XLEN  operand B to ALU rs2 (immediate or forwarded)
ex_store_data  output  XLEN  forwarded source-2 value for stores
ex_rd  output  5  registered destination index
ex_ctrl  output  4  registered control bundle, zero when not ex_valid
hazard  output  1  load-use detected; upstream SHALL hold PC and IF/ID

Function
REQ-003 SHALL update the stage register on each rising clk with priority flush > stall > hazard > normal load.
REQ-004 flush SHALL load a bubble: ex_valid=0, ex_ctrl=0, ex_rd=0, Alu_op=ALU_add, data fields zero.
REQ-005 stall (flush low) SHALL hold all registered fields, except as in REQ-010.
REQ-006 hazard SHALL be combinational: ex_valid & ex_ctrl[mem_read] & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2); when high with stall and flush low, the stage SHALL load a bubble.
REQ-007 normal load SHALL capture all id_* fields; id_valid=0 SHALL capture as a bubble.
REQ-008 Forwarding per source, combinational on registered index: EX/MEM result if exm_we & exm_rd!=0 & match; else MEM/WB result if wb_we & wb_rd!=0 & match; else registered register-file data; EX/MEM SHALL win when both match.
REQ-009 alu_b SHALL be registered immediate when registered alu_src=1, else forwarded source 2; ex_store_data SHALL always be forwarded source 2.
REQ-010 During stall, a registered rs1/rs2 data field SHALL be overwritten with wb_res when wb_we & wb_rd!=0 & wb_rd matches, so a retiring value is not lost.
REQ-011 Latency: one cycle from id_* to registered outputs; zero cycles from exm_*/wb_* to alu_a/alu_b/ex_store_data.

Reset
REQ-012 rst_n low SHALL asynchronously force the bubble of REQ-004, so hazard=0; state SHALL leave reset on the first clk edge after rst_n rises.

Structure
REQ-013 ALU opcode codes (ALU_add etc.), the id_ctrl bit positions and the bubble constant SHALL live in the shared def.h definitions package.
REQ-014 Per-source forwarding SHALL be one sub-module fwd_mux, instantiated twice.

Verification
REQ-015 Reset: rst_n=0 mid-operation -> ex_valid=0, ex_ctrl=0, hazard=0 immediately, without waiting for a clock edge.
REQ-016 Forward priority: ex_rs1=5, exm_rd=5/exm_res=0x11, wb_rd=5/wb_res=0x22 -> alu_a=0x11; exm_we=0 -> alu_a=0x22; rd=0 on both -> register-file data.
REQ-017 Load-use: EX holds load to x7, ID reads x7 -> hazard=1, next cycle ex_valid=0, then instruction enters with alu_a=wb_res.
REQ-018 Stall refresh: stall=1 for 3 cycles, wb writes x3=0xAB once, ex_rs2=3 -> after release ex_store_data=0xAB.
REQ-019 Flush over stall: flush=1, stall=1, id_valid=1 -> next cycle ex_valid=0, ex_ctrl=0.
REQ-020 Immediate select: alu_src=1, imm=0xFFFFFFFFFFFFFFFC -> alu_b=imm, ex_store_data=forwarded rs2.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX definitions: ALU opcodes, control-bundle bit positions, bubble constant.
// Also holds the forwarding-match helper used by every forwarding mux.
package id_ex_stage_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [2:0] {
        ALU_add = 3'd0,
        ALU_sub = 3'd1,
        ALU_and = 3'd2,
        ALU_or  = 3'd3,
        ALU_xor = 3'd4,
        ALU_sll = 3'd5,
        ALU_srl = 3'd6,
        ALU_slt = 3'd7
    } alu_op_e;

    // Control bundle layout: {reg_write, mem_read, mem_write, branch}
    localparam int CTRL_W         = 4;
    localparam int CTRL_REG_WRITE = 3;
    localparam int CTRL_MEM_READ  = 2;
    localparam int CTRL_MEM_WRITE = 1;
    localparam int CTRL_BRANCH    = 0;

    typedef struct packed {
        logic              valid;
        reg_idx_t          rs1;
        reg_idx_t          rs2;
        reg_idx_t          rd;
        alu_op_e           alu_op;
        logic              alu_src;
        logic [CTRL_W-1:0] ctrl;
    } ex_meta_t;

    localparam ex_meta_t EX_META_BUBBLE = '{
        valid:   1'b0,
        rs1:     5'd0,
        rs2:     5'd0,
        rd:      5'd0,
        alu_op:  ALU_add,
        alu_src: 1'b0,
        ctrl:    4'd0
    };

    // x0 never forwards: it is hardwired to zero in the register file.
    function automatic logic fwd_hit(input logic we, input reg_idx_t rd, input reg_idx_t idx);
        return we && (rd != 5'd0) && (rd == idx);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-source operand forwarding: EX/MEM result, else MEM/WB value, else register data.
// Latency: combinational. Backpressure: none.
// Purely combinational select; the caller supplies the registered source index.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [4:0]      src_idx,
    input  logic [XLEN-1:0] reg_dat,
    input  logic [4:0]      exm_rd,
    input  logic            exm_we,
    input  logic [XLEN-1:0] exm_res,
    input  logic [4:0]      wb_rd,
    input  logic            wb_we,
    input  logic [XLEN-1:0] wb_res,
    output logic [XLEN-1:0] fwd_dat
);

    // EX/MEM is the younger producer, so it outranks MEM/WB on a double match.
    always_comb begin
        fwd_dat = reg_dat;
        if (fwd_hit(exm_we, exm_rd, src_idx)) begin
            fwd_dat = exm_res;
        end else if (fwd_hit(wb_we, wb_rd, src_idx)) begin
            fwd_dat = wb_res;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Latency: 1 cycle id_* -> registered fields; 0 cycles exm_*/wb_* -> ALU operands.
// Backpressure: stall holds the stage, flush squashes it, hazard inserts a bubble.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_alu_op,
    input  logic            id_alu_src,
    input  logic [3:0]      id_ctrl,
    input  logic [4:0]      exm_rd,
    input  logic            exm_we,
    input  logic [XLEN-1:0] exm_res,
    input  logic [4:0]      wb_rd,
    input  logic            wb_we,
    input  logic [XLEN-1:0] wb_res,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [2:0]      Alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_ctrl,
    output logic            hazard
);

    ex_meta_t        meta_q, meta_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_dat_q, rs1_dat_d;
    logic [XLEN-1:0] rs2_dat_q, rs2_dat_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] src1_fwd, src2_fwd;
    logic            ex_is_load;
    logic            id_uses_ex_rd;

    // A load in EX cannot forward until MEM, so a dependent in ID must wait a cycle.
    assign ex_is_load    = meta_q.valid && meta_q.ctrl[CTRL_MEM_READ] && (meta_q.rd != 5'd0);
    assign id_uses_ex_rd = (meta_q.rd == id_rs1) || (meta_q.rd == id_rs2);
    assign hazard        = ex_is_load && id_valid && id_uses_ex_rd;

    always_comb begin
        meta_d    = meta_q;
        pc_d      = pc_q;
        rs1_dat_d = rs1_dat_q;
        rs2_dat_d = rs2_dat_q;
        imm_d     = imm_q;
        if (flush) begin
            meta_d    = EX_META_BUBBLE;
            pc_d      = '0;
            rs1_dat_d = '0;
            rs2_dat_d = '0;
            imm_d     = '0;
        end else if (stall) begin
            // The writeback port moves on while we hold; capture a retiring value now.
            if (fwd_hit(wb_we, wb_rd, meta_q.rs1)) begin
                rs1_dat_d = wb_res;
            end
            if (fwd_hit(wb_we, wb_rd, meta_q.rs2)) begin
                rs2_dat_d = wb_res;
            end
        end else if (hazard || !id_valid) begin
            meta_d    = EX_META_BUBBLE;
            pc_d      = '0;
            rs1_dat_d = '0;
            rs2_dat_d = '0;
            imm_d     = '0;
        end else begin
            meta_d.valid   = 1'b1;
            meta_d.rs1     = id_rs1;
            meta_d.rs2     = id_rs2;
            meta_d.rd      = id_rd;
            meta_d.alu_op  = alu_op_e'(id_alu_op);
            meta_d.alu_src = id_alu_src;
            meta_d.ctrl    = id_ctrl;
            pc_d           = id_pc;
            rs1_dat_d      = id_rs1_data;
            rs2_dat_d      = id_rs2_data;
            imm_d          = id_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q    <= EX_META_BUBBLE;
            pc_q      <= '0;
            rs1_dat_q <= '0;
            rs2_dat_q <= '0;
            imm_q     <= '0;
        end else begin
            meta_q    <= meta_d;
            pc_q      <= pc_d;
            rs1_dat_q <= rs1_dat_d;
            rs2_dat_q <= rs2_dat_d;
            imm_q     <= imm_d;
        end
    end

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .src_idx (meta_q.rs1),
        .reg_dat (rs1_dat_q),
        .exm_rd  (exm_rd),
        .exm_we  (exm_we),
        .exm_res (exm_res),
        .wb_rd   (wb_rd),
        .wb_we   (wb_we),
        .wb_res  (wb_res),
        .fwd_dat (src1_fwd)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .src_idx (meta_q.rs2),
        .reg_dat (rs2_dat_q),
        .exm_rd  (exm_rd),
        .exm_we  (exm_we),
        .exm_res (exm_res),
        .wb_rd   (wb_rd),
        .wb_we   (wb_we),
        .wb_res  (wb_res),
        .fwd_dat (src2_fwd)
    );

    assign ex_valid      = meta_q.valid;
    assign ex_pc         = pc_q;
    assign Alu_op        = meta_q.alu_op;
    assign ex_rd         = meta_q.rd;
    assign ex_ctrl       = meta_q.ctrl;
    assign alu_a         = src1_fwd;
    assign alu_b         = meta_q.alu_src ? imm_q : src2_fwd;
    assign ex_store_data = src2_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_id_ex_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall, flush, id_valid;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [2:0]      id_alu_op;
    logic            id_alu_src;
    logic [3:0]      id_ctrl;
    logic [4:0]      exm_rd, wb_rd;
    logic            exm_we, wb_we;
    logic [XLEN-1:0] exm_res, wb_res;
    logic            ex_valid, hazard;
    logic [XLEN-1:0] ex_pc, alu_a, alu_b, ex_store_data;
    logic [2:0]      Alu_op;
    logic [4:0]      ex_rd;
    logic [3:0]      ex_ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the execute slot contents.
    logic            m_valid, m_src;
    logic [XLEN-1:0] m_pc, m_a, m_b, m_imm;
    logic [4:0]      m_rs1, m_rs2, m_rd;
    logic [2:0]      m_op;
    logic [3:0]      m_ctrl;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_ctrl(id_ctrl),
        .exm_rd(exm_rd), .exm_we(exm_we), .exm_res(exm_res),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_res(wb_res),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .Alu_op(Alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .hazard(hazard)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] fwd(input logic [4:0] idx, input logic [XLEN-1:0] rf);
        if (exm_we && exm_rd != 0 && exm_rd == idx) return exm_res;
        if (wb_we && wb_rd != 0 && wb_rd == idx) return wb_res;
        return rf;
    endfunction

    // ctrl bit 2 is mem_read in {reg_write, mem_read, mem_write, branch}
    function automatic logic exp_hazard();
        return m_valid && m_ctrl[2] && m_rd != 0 && id_valid && (m_rd == id_rs1 || m_rd == id_rs2);
    endfunction

    task automatic model_bubble();
        m_valid = 0; m_src = 0; m_pc = 0; m_a = 0; m_b = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 3'd0; m_ctrl = 0;
    endtask

    task automatic model_update();
        logic h;
        h = exp_hazard();
        if (flush) model_bubble();
        else if (stall) begin
            if (wb_we && wb_rd != 0 && wb_rd == m_rs1) m_a = wb_res;
            if (wb_we && wb_rd != 0 && wb_rd == m_rs2) m_b = wb_res;
        end else if (h || !id_valid) model_bubble();
        else begin
            m_valid = 1; m_src = id_alu_src; m_pc = id_pc; m_a = id_rs1_data; m_b = id_rs2_data;
            m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_op = id_alu_op;
            m_ctrl = id_ctrl;
        end
    endtask

    task automatic check_outputs();
        check("ex_valid", 64'(ex_valid), 64'(m_valid));
        check("ex_pc", ex_pc, m_pc);
        check("Alu_op", 64'(Alu_op), 64'(m_op));
        check("ex_rd", 64'(ex_rd), 64'(m_rd));
        check("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
        check("alu_a", alu_a, fwd(m_rs1, m_a));
        check("alu_b", alu_b, m_src ? m_imm : fwd(m_rs2, m_b));
        check("store_data", ex_store_data, fwd(m_rs2, m_b));
        check("hazard", 64'(hazard), 64'(exp_hazard()));
    endtask

    // Check at negedge, then advance one clock and the model with it.
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                          input logic [63:0] imm, input logic src, input logic [3:0] ctrl);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_data = d1;
        id_rs2_data = d2; id_imm = imm; id_alu_src = src; id_ctrl = ctrl;
        id_pc = {$urandom, $urandom}; id_alu_op = 3'($urandom_range(0, 7));
    endtask

    task automatic clear_fwd();
        exm_we = 0; exm_rd = 0; exm_res = 0; wb_we = 0; wb_rd = 0; wb_res = 0;
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        clear_fwd();
        model_bubble();
        #12;
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_ex_ctrl", 64'(ex_ctrl), 64'd0);
        check("rst_Alu_op", 64'(Alu_op), 64'd0);
        check("rst_hazard", 64'(hazard), 64'd0);
        #10 rst_n = 1;
        @(posedge clk); #1;

        // Forward priority on source 1 (x5)
        set_id(1, 5, 6, 1, 64'h99, 64'h66, 64'h0, 0, 4'b1000);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        exm_we = 1; exm_rd = 5; exm_res = 64'h11; wb_we = 1; wb_rd = 5; wb_res = 64'h22;
        #1 check("fwd_exm_wins", alu_a, 64'h11);
        exm_we = 0;
        #1 check("fwd_wb", alu_a, 64'h22);
        exm_we = 1; exm_rd = 0; wb_rd = 0;
        #1 check("fwd_rd0_regfile", alu_a, 64'h99);
        clear_fwd();
        step();

        // Load-use on x7
        set_id(1, 1, 2, 7, 64'h10, 64'h20, 64'h8, 1, 4'b1100);
        step();
        set_id(1, 7, 4, 9, 64'h5555, 64'h4444, 64'h0, 0, 4'b1000);
        #1 check("loaduse_hazard", 64'(hazard), 64'd1);
        step();
        check("loaduse_bubble", 64'(ex_valid), 64'd0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb_we = 1; wb_rd = 7; wb_res = 64'h77;
        #1 check("loaduse_alu_a", alu_a, 64'h77);
        check("loaduse_valid", 64'(ex_valid), 64'd1);
        clear_fwd();
        step();

        // Stall refresh of source 2 (x3)
        set_id(1, 1, 3, 4, 64'h0, 64'h1, 64'h0, 0, 4'b0010);
        step();
        stall = 1;
        wb_we = 1; wb_rd = 3; wb_res = 64'hAB;
        step();
        clear_fwd();
        step();
        step();
        stall = 0;
        #1 check("stall_refresh", ex_store_data, 64'hAB);
        step();

        // Flush beats stall
        flush = 1; stall = 1;
        set_id(1, 2, 3, 4, 64'h1, 64'h2, 64'h3, 0, 4'b1000);
        step();
        check("flush_valid", 64'(ex_valid), 64'd0);
        check("flush_ctrl", 64'(ex_ctrl), 64'd0);
        flush = 0; stall = 0;

        // Immediate select
        set_id(1, 8, 9, 10, 64'h1, 64'h1234, 64'hFFFFFFFFFFFFFFFC, 1, 4'b1000);
        step();
        check("imm_alu_b", alu_b, 64'hFFFFFFFFFFFFFFFC);
        check("imm_store_data", ex_store_data, 64'h1234);

        // Async reset in the middle of a load-use hazard
        set_id(1, 1, 2, 7, 64'h10, 64'h20, 64'h8, 1, 4'b1100);
        step();
        set_id(1, 7, 7, 9, 64'h1, 64'h2, 64'h0, 0, 4'b1000);
        #1 check("pre_rst_hazard", 64'(hazard), 64'd1);
        rst_n = 0;
        #1 check("mid_rst_ex_valid", 64'(ex_valid), 64'd0);
        check("mid_rst_ex_ctrl", 64'(ex_ctrl), 64'd0);
        check("mid_rst_hazard", 64'(hazard), 64'd0);
        model_bubble();
        rst_n = 1;
        step();

        // Randomized traffic with small register indices to force collisions
        for (int i = 0; i < 400; i++) begin
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 4) == 0);
            set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, 1'($urandom), 4'($urandom));
            exm_we = 1'($urandom); exm_rd = 5'($urandom_range(0, 7)); exm_res = {$urandom, $urandom};
            wb_we  = 1'($urandom); wb_rd  = 5'($urandom_range(0, 7)); wb_res  = {$urandom, $urandom};
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
